wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle MDU result path.
//  Pipeline writes have priority. MDU results queue in a small FIFO and drain into idle writeback slots.
//  A starvation counter forces a one-cycle pipeline stall so a queued result always retires.
//  Also reports pending destinations to the hazard unit so it can block WAW/RAW on queued results.
// PARAMETERS
//  WORD_SIZE    32  data width of the register-file write port
//  REG_SIZE     5   register index width
//  DEPTH        2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 4   cycles a head entry may wait before a forced stall (>=1)
// PORTS
//  clk             in   1          system clock, rising edge
//  rst_n           in   1          synchronous reset, active-low
//  pipe_reg_write  in   1          WB-stage RegWrite
//  pipe_dest_reg   in   REG_SIZE   WB-stage destination register
//  pipe_write_data in   WORD_SIZE  WB-stage write data (MemtoReg mux output)
//  mdu_valid       in   1          MDU result valid
//  mdu_dest_reg    in   REG_SIZE   MDU destination register
//  mdu_data        in   WORD_SIZE  MDU result
//  mdu_ready       out  1          FIFO can accept (!full); MDU transfer = valid & ready
//  pend_query_reg  in   REG_SIZE   register queried by the hazard unit
//  pend_hit        out  1          a valid FIFO entry targets pend_query_reg (0 if the query is x0)
//  pipe_stall      out  1          WB must hold its instruction this cycle
//  rf_we           out  1          register-file write enable
//  rf_waddr        out  REG_SIZE   register-file write address
//  rf_wdata        out  WORD_SIZE  register-file write data
// BEHAVIOUR
//  Reset: any edge with rst_n=0 empties the FIFO, zeroes the pointers and starve counter, and sets state=IDLE.
//   rf_we, pipe_stall, mdu_ready and pend_hit are gated to 0 combinationally while rst_n=0.
//   A transfer presented during reset is dropped.
//  pipe_busy = pipe_reg_write & (pipe_dest_reg!=0). Writes to x0 never assert rf_we. MDU results for x0 are accepted and discarded, never enqueued.
//  FSM (registered state):
//   IDLE:  FIFO empty. Port = pipeline. Enqueue -> DRAIN.
//   DRAIN: FIFO non-empty.
//     If !pipe_busy: port = FIFO head, pop, starve=0.
//     Else: port = pipeline, starve++.
//     starve reaches STARVE_LIMIT -> FORCE. Empty after pop with no push -> IDLE.
//   FORCE: pipe_stall=1; port = FIFO head, pop, starve=0.
//     Next state is DRAIN if entries remain, else IDLE.
//     The pipeline must present the same WB instruction again in the following cycle.
//  Push and pop in the same cycle are legal: count is unchanged and ordering is preserved. mdu_ready stays 0 while full, even if a pop occurs that cycle.
//  Port outputs are combinational from the current state and inputs. The register file samples them at the next edge, so write latency = 0 cycles from selection.
//  FIFO pointers wrap modulo DEPTH. The count register is REG_SIZE-independent, sized $clog2(DEPTH)+1.
//  WAW ordering is the hazard unit's duty: it must not issue a writer of R while pend_hit(R)=1. The arbiter does not reorder or check this.
//  pend_hit is combinational over the valid entries only.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   In IDLE with mdu_valid & !pipe_busy, the MDU result drives the port in the same cycle and is not enqueued (0-cycle latency).
//  Undefined:
//   Every MDU result is enqueued and retires no earlier than the next cycle.
// STRUCTURE
//  Package wb_arb_pkg holds:
//   - WORD_SIZE and REG_SIZE constants
//   - state enum {IDLE, DRAIN, FORCE}
//   - the entry struct {dest, data}
//  Sub-module wb_arb_fifo (DEPTH entries, push/pop/full/empty, parallel dest taps for pend_hit). The FSM, starve counter and port mux stay in the top level.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with mdu_valid=1 -> rf_we=0, mdu_ready=0, FIFO empty after release.
//  2. Idle slot: mdu x5=0xDEADBEEF, pipe idle. Without WB_BYPASS_EN -> rf write x5 in the next cycle. With it -> the same cycle.
//  3. Collision: pipe writes x3=0x11 every cycle, mdu x7=0x22 queued -> pipe wins 4 cycles.
//     Cycle 5: pipe_stall=1 and rf x7=0x22. Cycle 6: rf x3=0x11 retried.
//  4. Full: 3 back-to-back MDU results with pipe busy -> mdu_ready=0 after 2. Entries drain in order once the pipe idles.
//  5. x0: mdu x0 and pipe x0 writes -> rf_we never 1, FIFO count stays 0.
//  6. pend_hit: queue x9, query x9 -> 1. Query x8 -> 0. After the drain, query x9 -> 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_SIZE  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [REG_SIZE-1:0]  dest;
        logic [WORD_SIZE-1:0] data;
    } arb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small MDU result FIFO with per-entry destination taps for hazard lookup.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  arb_entry_t                push_entry,
    output arb_entry_t                head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          valid_taps,
    output logic [DEPTH*REG_SIZE-1:0] dest_taps
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    arb_entry_t       mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clr_s;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // One-hot valid-bit updates for the slots being written and retired.
    always_comb begin
        set_s = {DEPTH{1'b0}};
        clr_s = {DEPTH{1'b0}};
        if (push_s) begin
            set_s[wr_ptr_r] = 1'b1;
        end else begin
            set_s = {DEPTH{1'b0}};
        end
        if (pop_s) begin
            clr_s[rd_ptr_r] = 1'b1;
        end else begin
            clr_s = {DEPTH{1'b0}};
        end
    end

    // Pointer, occupancy and valid-bit state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            valid_r <= (valid_r & ~clr_s) | set_s;
        end
    end

    // Entry storage needs no reset: valid_r qualifies every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_taps
        assign dest_taps[i*REG_SIZE +: REG_SIZE] = mem_r[i].dest;
    end

    assign head       = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign valid_taps = valid_r;

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and queued MDU results.
// Optional feature: define WB_BYPASS_EN to let an MDU result use an idle slot in the same cycle.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_reg_write,
    input  logic [REG_SIZE-1:0]  pipe_dest_reg,
    input  logic [WORD_SIZE-1:0] pipe_write_data,
    input  logic                 mdu_valid,
    input  logic [REG_SIZE-1:0]  mdu_dest_reg,
    input  logic [WORD_SIZE-1:0] mdu_data,
    output logic                 mdu_ready,
    input  logic [REG_SIZE-1:0]  pend_query_reg,
    output logic                 pend_hit,
    output logic                 pipe_stall,
    output logic                 rf_we,
    output logic [REG_SIZE-1:0]  rf_waddr,
    output logic [WORD_SIZE-1:0] rf_wdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t              state_r;
    arb_state_t              state_next_s;
    logic [SW-1:0]           starve_r;
    logic [SW-1:0]           starve_inc_s;
    logic                    pipe_busy_s;
    logic                    xfer_s;
    logic                    bypass_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    sel_fifo_s;
    logic                    stall_s;
    logic                    leaves_empty_s;
    logic                    hit_s;
    logic                    full_s;
    logic                    empty_s;
    logic [CW-1:0]           count_s;
    logic [DEPTH-1:0]        valid_taps_s;
    logic [DEPTH*REG_SIZE-1:0] dest_taps_s;
    arb_entry_t              head_s;
    arb_entry_t              mdu_entry_s;

    assign pipe_busy_s  = pipe_reg_write & (pipe_dest_reg != REG_SIZE'(0));
    assign mdu_ready    = rst_n & ~full_s;
    assign xfer_s       = mdu_valid & mdu_ready;
    assign starve_inc_s = starve_r + SW'(1);
    assign mdu_entry_s  = '{dest: mdu_dest_reg, data: mdu_data};

`ifdef WB_BYPASS_EN
    assign bypass_s = (state_r == IDLE) & xfer_s & ~pipe_busy_s &
                      (mdu_dest_reg != REG_SIZE'(0));
`else
    assign bypass_s = 1'b0;
`endif

    // x0 results are accepted but dropped; bypassed results never enter the queue.
    assign push_s         = xfer_s & (mdu_dest_reg != REG_SIZE'(0)) & ~bypass_s;
    assign leaves_empty_s = (count_s == CW'(1)) & pop_s & ~push_s;

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (mdu_entry_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count_s),
        .valid_taps (valid_taps_s),
        .dest_taps  (dest_taps_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Starvation counter: counts cycles the queue head loses to the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_r <= {SW{1'b0}};
        end else if ((state_r == DRAIN) && pipe_busy_s) begin
            starve_r <= starve_inc_s;
        end else begin
            starve_r <= {SW{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (push_s) state_next_s = DRAIN;
                else        state_next_s = IDLE;
            end
            DRAIN: begin
                if (!pipe_busy_s) begin
                    state_next_s = leaves_empty_s ? IDLE : DRAIN;
                end else if (starve_inc_s == SW'(STARVE_LIMIT)) begin
                    state_next_s = FORCE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            FORCE:   state_next_s = leaves_empty_s ? IDLE : DRAIN;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: port source, pop and stall per state.
    always_comb begin
        sel_fifo_s = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                sel_fifo_s = 1'b0;
                stall_s    = 1'b0;
            end
            DRAIN: begin
                sel_fifo_s = ~pipe_busy_s;
                stall_s    = 1'b0;
            end
            FORCE: begin
                sel_fifo_s = 1'b1;
                stall_s    = 1'b1;
            end
            default: begin
                sel_fifo_s = 1'b0;
                stall_s    = 1'b0;
            end
        endcase
        pop_s = sel_fifo_s & ~empty_s;
    end

    // Write-port mux; the register file samples these at the next edge.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pipe_dest_reg;
        rf_wdata = pipe_write_data;
        if (sel_fifo_s) begin
            rf_we    = rst_n & ~empty_s;
            rf_waddr = head_s.dest;
            rf_wdata = head_s.data;
        end else if (bypass_s) begin
            rf_we    = rst_n;
            rf_waddr = mdu_dest_reg;
            rf_wdata = mdu_data;
        end else begin
            rf_we    = rst_n & pipe_busy_s;
            rf_waddr = pipe_dest_reg;
            rf_wdata = pipe_write_data;
        end
        pipe_stall = rst_n & stall_s;
    end

    // Pending-destination lookup over valid queue entries only.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_taps_s[i] && (dest_taps_s[i*REG_SIZE +: REG_SIZE] == pend_query_reg)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        pend_hit = rst_n & hit_s & (pend_query_reg != REG_SIZE'(0));
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench: expected register-file writes are queued as stimulus is driven.
module tb_wb_write_arbiter;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_reg_write;
    logic [4:0]  pipe_dest_reg;
    logic [31:0] pipe_write_data;
    logic        mdu_valid;
    logic [4:0]  mdu_dest_reg;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  pend_query_reg;
    logic        pend_hit;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    always #5 clk = ~clk;

    wb_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipe_reg_write  (pipe_reg_write),
        .pipe_dest_reg   (pipe_dest_reg),
        .pipe_write_data (pipe_write_data),
        .mdu_valid       (mdu_valid),
        .mdu_dest_reg    (mdu_dest_reg),
        .mdu_data        (mdu_data),
        .mdu_ready       (mdu_ready),
        .pend_query_reg  (pend_query_reg),
        .pend_hit        (pend_hit),
        .pipe_stall      (pipe_stall),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata)
    );

    // Scoreboard: every committed write must match the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got x%0d=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_write: got x%0d=%h, required x%0d=%h",
                             rf_waddr, rf_wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdu_valid = 1'b1; mdu_dest_reg = 5'd5; mdu_data = 32'hCAFE_0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b0 || mdu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: we=%b ready=%b stall=%b, required 0 0 0", rf_we, mdu_ready, pipe_stall);
            end
            tick();
        end
        rst_n = 1'b1; mdu_valid = 1'b0; pend_query_reg = 5'd5;
        #1;
        checks++;
        if (pend_hit !== 1'b0 || mdu_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: hit=%b ready=%b we=%b, required 0 1 0", pend_hit, mdu_ready, rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo_empty: we=%b, required 0", rf_we);
        end
        tick();
    endtask

    task automatic test_idle_slot();
        mdu_valid = 1'b1; mdu_dest_reg = 5'd5; mdu_data = 32'hDEAD_BEEF;
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        #1;
        checks++;
        if (rf_we !== BYP) begin
            errors++;
            $display("FAIL idle_same_cycle: we=%b, required %b", rf_we, BYP);
        end
        tick();
        mdu_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== ~BYP || (!BYP && rf_waddr !== 5'd5)) begin
            errors++;
            $display("FAIL idle_next_cycle: we=%b addr=%0d, required we=%b addr=5", rf_we, rf_waddr, ~BYP);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [4:0] ea;
        pipe_reg_write = 1'b1; pipe_dest_reg = 5'd3; pipe_write_data = 32'h11;
        mdu_valid = 1'b1; mdu_dest_reg = 5'd7; mdu_data = 32'h22;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) mdu_valid = 1'b0;
            ea = (i == 5) ? 5'd7 : 5'd3;
            exp_q.push_back((i == 5) ? {5'd7, 32'h22} : {5'd3, 32'h11});
            #1;
            checks++;
            if (pipe_stall !== (i == 5) || rf_waddr !== ea || rf_we !== 1'b1) begin
                errors++;
                $display("FAIL collision_c%0d: stall=%b addr=%0d we=%b, required stall=%b addr=%0d we=1",
                         i, pipe_stall, rf_waddr, rf_we, (i == 5), ea);
            end
            tick();
        end
        pipe_reg_write = 1'b0;
    endtask

    task automatic test_full();
        logic exp_rdy;
        pipe_dest_reg = 5'd3; pipe_write_data = 32'h11;
        for (int i = 0; i < 7; i++) begin
            pipe_reg_write = (i < 3);
            mdu_valid      = (i < 5);
            mdu_dest_reg   = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
            mdu_data       = 32'hA000 + 32'(mdu_dest_reg);
            exp_rdy        = !(i == 2 || i == 3);
            case (i)
                0, 1, 2: exp_q.push_back({5'd3, 32'h11});
                3:       exp_q.push_back({5'd10, 32'hA00A});
                4:       exp_q.push_back({5'd11, 32'hA00B});
                5:       exp_q.push_back({5'd12, 32'hA00C});
                default: ;
            endcase
            #1;
            checks++;
            if (mdu_ready !== exp_rdy || rf_we !== (i < 6)) begin
                errors++;
                $display("FAIL full_c%0d: ready=%b we=%b, required ready=%b we=%b", i, mdu_ready, rf_we, exp_rdy, (i < 6));
            end
            tick();
        end
    endtask

    task automatic test_x0();
        pipe_reg_write = 1'b1; pipe_dest_reg = 5'd0; pipe_write_data = 32'hFFFF;
        mdu_valid = 1'b1; mdu_dest_reg = 5'd0; mdu_data = 32'h1234; pend_query_reg = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                pipe_reg_write = 1'b0; mdu_valid = 1'b0;
            end
            #1;
            checks++;
            if (rf_we !== 1'b0 || mdu_ready !== 1'b1 || pend_hit !== 1'b0) begin
                errors++;
                $display("FAIL x0_c%0d: we=%b ready=%b hit=%b, required 0 1 0", i, rf_we, mdu_ready, pend_hit);
            end
            tick();
        end
    endtask

    task automatic test_pend_hit();
        pipe_reg_write = 1'b1; pipe_dest_reg = 5'd3; pipe_write_data = 32'h11;
        mdu_valid = 1'b1; mdu_dest_reg = 5'd9; mdu_data = 32'h9999; pend_query_reg = 5'd9;
        exp_q.push_back({5'd3, 32'h11});
        #1;
        checks++;
        if (pend_hit !== 1'b0) begin
            errors++;
            $display("FAIL pend_before: hit=%b, required 0", pend_hit);
        end
        tick();
        mdu_valid = 1'b0;
        exp_q.push_back({5'd3, 32'h11});
        #1;
        checks++;
        if (pend_hit !== 1'b1) begin
            errors++;
            $display("FAIL pend_x9: hit=%b, required 1", pend_hit);
        end
        pend_query_reg = 5'd8;
        #1;
        checks++;
        if (pend_hit !== 1'b0) begin
            errors++;
            $display("FAIL pend_x8: hit=%b, required 0", pend_hit);
        end
        tick();
        pipe_reg_write = 1'b0; pend_query_reg = 5'd9;
        exp_q.push_back({5'd9, 32'h9999});
        tick();
        #1;
        checks++;
        if (pend_hit !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL pend_after_drain: hit=%b we=%b, required 0 0", pend_hit, rf_we);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_reg_write = 1'b0; pipe_dest_reg = 5'd0; pipe_write_data = 32'h0;
        mdu_valid = 1'b0; mdu_dest_reg = 5'd0; mdu_data = 32'h0; pend_query_reg = 5'd0;
        test_reset();
        test_idle_slot();
        test_collision();
        test_full();
        test_x0();
        test_pend_hit();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
